// File: rtl/breakout_pkg.sv
// Shared breakout geometry, brick grid sizing and scheduler state encoding.
// Imported by the physics scheduler and the pixel/RGB logic.
package breakout_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned LEFT_WALL_X   = 190;
  localparam int unsigned RIGHT_WALL_X  = 790;
  localparam int unsigned CEILING_Y     = 35;
  localparam int unsigned FLOOR_Y       = 515;
  localparam int unsigned GRID_BOTTOM_Y = 160;
  localparam int unsigned BALL_STEP     = 2;
  localparam int unsigned START_LIVES   = 3;

  localparam int unsigned GRID_ROWS  = 5;
  localparam int unsigned GRID_COLS  = 12;
  localparam int unsigned NUM_BRICKS = GRID_ROWS * GRID_COLS;
  localparam int unsigned BRICK_W    = (RIGHT_WALL_X - LEFT_WALL_X) / GRID_COLS;
  localparam int unsigned BRICK_H    = (GRID_BOTTOM_Y - CEILING_Y) / GRID_ROWS;

  localparam int unsigned BALL_HALF     = 5;
  localparam int unsigned PADDLE_W      = 51;
  localparam int unsigned PADDLE_H      = 11;
  localparam int unsigned PADDLE_Y      = 500;
  localparam int unsigned PADDLE_HALF_W = (PADDLE_W - 1) / 2;
  localparam int unsigned PADDLE_HALF_H = (PADDLE_H - 1) / 2;
  // Ball resting one pixel above the paddle top after a bounce.
  localparam int unsigned PADDLE_BOUNCE_Y = PADDLE_Y - PADDLE_HALF_H - BALL_HALF - 1;

  localparam int unsigned SPAWN_X = 450;
  localparam int unsigned SPAWN_Y = 480;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_WALL,
    ST_PADDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  function automatic coord_t brick_x0(input logic [3:0] col);
    return coord_t'(LEFT_WALL_X + 32'(col) * BRICK_W);
  endfunction

  function automatic coord_t brick_y0(input logic [2:0] row);
    return coord_t'(CEILING_Y + 32'(row) * BRICK_H);
  endfunction

endpackage

// File: rtl/rect_overlap.sv
// Combinational test: does the ball box (centre +/- BALL_HALF) touch a target box?
// All edges inclusive; the ball's left/top edge saturates at zero.
module rect_overlap
  import breakout_pkg::*;
(
  input  logic [9:0] cx,
  input  logic [9:0] cy,
  input  logic [9:0] x0,
  input  logic [9:0] x1,
  input  logic [9:0] y0,
  input  logic [9:0] y1,
  output logic       hit
);

  logic [10:0] bl, br, bt, bb;

  always_comb begin
    bl  = (cx >= coord_t'(BALL_HALF)) ? {1'b0, cx - coord_t'(BALL_HALF)} : 11'd0;
    br  = {1'b0, cx} + 11'(BALL_HALF);
    bt  = (cy >= coord_t'(BALL_HALF)) ? {1'b0, cy - coord_t'(BALL_HALF)} : 11'd0;
    bb  = {1'b0, cy} + 11'(BALL_HALF);
    hit = (bl <= {1'b0, x1}) && (br >= {1'b0, x0}) &&
          (bt <= {1'b0, y1}) && (bb >= {1'b0, y0});
  end

endmodule

// File: rtl/ball_physics_scheduler.sv
// One breakout physics update per move_tick: step, bounce, then a one-brick-per-clk grid scan.
//   state  | meaning
//   IDLE   | waiting for move_tick (ignored once game_over)
//   MOVE   | step ball by BALL_STEP on both axes
//   WALL   | wall/ceiling clamp and bounce; floor loses a life and respawns
//   PADDLE | bounce off paddle when moving down
//   SCAN   | test one brick per clk, first unhit overlap wins
//   DONE   | frame_done pulse, all-bricks game-over check
module ball_physics_scheduler
  import breakout_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        move_tick,
  input  logic [9:0]  paddle_x,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [59:0] hit_map,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        busy,
  output logic        frame_done
);

  localparam coord_t X_MIN     = coord_t'(LEFT_WALL_X + BALL_HALF);
  localparam coord_t X_MAX     = coord_t'(RIGHT_WALL_X - BALL_HALF);
  localparam coord_t Y_MIN     = coord_t'(CEILING_Y + BALL_HALF);
  localparam coord_t Y_FLOOR   = coord_t'(FLOOR_Y - BALL_HALF);
  localparam coord_t STEP      = coord_t'(BALL_STEP);
  localparam coord_t PAD_HW    = coord_t'(PADDLE_HALF_W);
  localparam coord_t PAD_X_LIM = coord_t'(1023 - PADDLE_HALF_W);
  localparam logic [5:0] LAST_IDX = 6'(NUM_BRICKS - 1);
  localparam logic [3:0] LAST_COL = 4'(GRID_COLS - 1);

  state_t      state_q, state_d;
  coord_t      bx_d, by_d;
  logic        dir_x, dir_y, dx_d, dy_d;
  logic [59:0] map_d;
  logic [7:0]  score_d;
  logic [1:0]  lives_d;
  logic        go_d;
  logic [2:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [5:0]  idx_q, idx_d;

  coord_t pad_x0, pad_x1, brk_x0, brk_y0;
  logic   paddle_hit, brick_hit;

  always_comb begin
    pad_x0 = (paddle_x >= PAD_HW) ? paddle_x - PAD_HW : '0;
    pad_x1 = (paddle_x > PAD_X_LIM) ? '1 : paddle_x + PAD_HW;
    brk_x0 = brick_x0(col_q);
    brk_y0 = brick_y0(row_q);
  end

  rect_overlap u_paddle_hit (
    .cx (ball_x),
    .cy (ball_y),
    .x0 (pad_x0),
    .x1 (pad_x1),
    .y0 (coord_t'(PADDLE_Y - PADDLE_HALF_H)),
    .y1 (coord_t'(PADDLE_Y + PADDLE_HALF_H)),
    .hit(paddle_hit)
  );

  rect_overlap u_brick_hit (
    .cx (ball_x),
    .cy (ball_y),
    .x0 (brk_x0),
    .x1 (brk_x0 + coord_t'(BRICK_W - 1)),
    .y0 (brk_y0),
    .y1 (brk_y0 + coord_t'(BRICK_H - 1)),
    .hit(brick_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ball_x    <= coord_t'(SPAWN_X);
      ball_y    <= coord_t'(SPAWN_Y);
      dir_x     <= 1'b1;
      dir_y     <= 1'b0;
      hit_map   <= '0;
      score     <= '0;
      lives     <= 2'(START_LIVES);
      game_over <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      ball_x    <= bx_d;
      ball_y    <= by_d;
      dir_x     <= dx_d;
      dir_y     <= dy_d;
      hit_map   <= map_d;
      score     <= score_d;
      lives     <= lives_d;
      game_over <= go_d;
      row_q     <= row_d;
      col_q     <= col_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bx_d    = ball_x;
    by_d    = ball_y;
    dx_d    = dir_x;
    dy_d    = dir_y;
    map_d   = hit_map;
    score_d = score;
    lives_d = lives;
    go_d    = game_over;
    row_d   = row_q;
    col_d   = col_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: if (move_tick && !game_over) state_d = ST_MOVE;
      ST_MOVE: begin
        bx_d    = dir_x ? ball_x + STEP : ball_x - STEP;
        by_d    = dir_y ? ball_y + STEP : ball_y - STEP;
        state_d = ST_WALL;
      end
      ST_WALL: begin
        if (ball_x <= X_MIN) begin dx_d = 1'b1; bx_d = X_MIN; end
        if (ball_x >= X_MAX) begin dx_d = 1'b0; bx_d = X_MAX; end
        if (ball_y <= Y_MIN) begin dy_d = 1'b1; by_d = Y_MIN; end
        // Floor loss overrides any clamp above: the ball respawns.
        if (ball_y >= Y_FLOOR) begin
          if (lives != 2'd0) lives_d = lives - 2'd1;
          if (lives <= 2'd1) go_d = 1'b1;
          bx_d    = coord_t'(SPAWN_X);
          by_d    = coord_t'(SPAWN_Y);
          dx_d    = 1'b1;
          dy_d    = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_PADDLE;
        end
      end
      ST_PADDLE: begin
        if (dir_y && paddle_hit) begin
          dy_d = 1'b0;
          by_d = coord_t'(PADDLE_BOUNCE_Y);
        end
        row_d   = '0;
        col_d   = '0;
        idx_d   = '0;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!hit_map[idx_q] && brick_hit) begin
          map_d[idx_q] = 1'b1;
          score_d      = (score == 8'hFF) ? score : score + 8'd1;
          dy_d         = ~dir_y;
          state_d      = ST_DONE;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 6'd1;
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      ST_DONE: begin
        if (&hit_map) go_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_ball_physics_scheduler.sv
// Directed trajectory bench: ball flown from reset through brick hits, walls, paddle and floor losses.
// Expected positions are hand-derived from the 2 px/tick diagonal path.
module tb_ball_physics_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        move_tick;
  logic [9:0]  paddle_x;
  logic [9:0]  ball_x, ball_y;
  logic [59:0] hit_map;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        game_over, busy, frame_done;

  int total = 0;
  int bad   = 0;

  ball_physics_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .move_tick (move_tick),
    .paddle_x  (paddle_x),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .hit_map   (hit_map),
    .score     (score),
    .lives     (lives),
    .game_over (game_over),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_ball(input string tag, input int x, input int y);
    check({tag, "_x"}, 64'(ball_x), 64'(x));
    check({tag, "_y"}, 64'(ball_y), 64'(y));
  endtask

  // Returns clks from the sampling edge to the frame_done cycle (0 on timeout).
  task automatic run_tick(output int lat, output int busy_n);
    int n;
    lat    = 0;
    busy_n = 0;
    @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    n = 1;
    while (lat == 0 && n <= 200) begin
      if (busy) busy_n++;
      if (frame_done) lat = n;
      else begin
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic run_ticks(input int cnt, input string tag);
    int odd, l, b;
    odd = 0;
    for (int i = 0; i < cnt; i++) begin
      run_tick(l, b);
      if (l != 64) odd++;
    end
    check(tag, 64'(odd), 64'd0);
  endtask

  initial begin
    int lat, bn, n, extra;
    logic [59:0] exp_map;

    rst       = 1'b1;
    move_tick = 1'b0;
    paddle_x  = 10'd900;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_ball("rst_ball", 450, 480);
    check("rst_map", 64'(hit_map), 64'd0);
    check("rst_score", 64'(score), 64'd0);
    check("rst_lives", 64'(lives), 64'd3);
    check("rst_go", 64'(game_over), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fd", 64'(frame_done), 64'd0);

    // Trip 1: straight up-right, brick 59, right wall, floor loss.
    run_tick(lat, bn);
    check("t1_lat", 64'(lat), 64'd64);
    check("t1_busy", 64'(bn), 64'd64);
    check_ball("t1", 452, 478);
    check("t1_map", 64'(hit_map), 64'd0);

    // Second tick with a stray move_tick while busy.
    @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    repeat (9) @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    n = 11;
    while (!frame_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t2_lat", 64'(n), 64'd64);
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (frame_done) extra++;
    end
    check("t2_extra_fd", 64'(extra), 64'd0);
    check_ball("t2", 454, 476);

    run_ticks(155, "t3_157_lat");
    check_ball("t157", 764, 166);
    check("t157_score", 64'(score), 64'd0);

    run_tick(lat, bn);
    exp_map = '0;
    exp_map[59] = 1'b1;
    check("t158_lat", 64'(lat), 64'd64);
    check_ball("t158", 766, 164);
    check("t158_map", 64'(hit_map), 64'(exp_map));
    check("t158_score", 64'(score), 64'd1);

    run_ticks(9, "t159_167_lat");
    check_ball("t167", 784, 182);
    run_tick(lat, bn);
    check("t168_lat", 64'(lat), 64'd64);
    check_ball("t168_wall", 785, 184);
    run_tick(lat, bn);
    check_ball("t169", 783, 186);

    run_ticks(161, "t170_330_lat");
    check_ball("t330", 461, 508);
    run_tick(lat, bn);
    check("t331_lat", 64'(lat), 64'd3);
    check("t331_lives", 64'(lives), 64'd2);
    check_ball("t331_spawn", 450, 480);
    check("t331_go", 64'(game_over), 64'd0);
    check("t331_score", 64'(score), 64'd1);

    // Trip 2: brick 47 near the right wall, paddle bounce, left wall, straddle hit, second loss.
    paddle_x = 10'd430;
    run_tick(lat, bn);
    check_ball("s1", 452, 478);
    run_ticks(169, "s2_170_lat");
    check_ball("s170", 781, 140);
    run_tick(lat, bn);
    exp_map[47] = 1'b1;
    check_ball("s171", 779, 138);
    check("s171_map", 64'(hit_map), 64'(exp_map));
    check("s171_score", 64'(score), 64'd2);

    run_ticks(175, "s172_346_lat");
    check_ball("s346", 429, 488);
    run_tick(lat, bn);
    check("s347_lat", 64'(lat), 64'd64);
    check_ball("s347_paddle", 427, 489);
    check("s347_lives", 64'(lives), 64'd2);

    run_ticks(162, "up_lat");
    check_ball("up162", 287, 165);
    run_tick(lat, bn);
    exp_map[49] = 1'b1;
    check_ball("up163", 289, 163);
    check("up163_map", 64'(hit_map), 64'(exp_map));
    check("up163_score", 64'(score), 64'd3);
    run_tick(lat, bn);
    check_ball("up164", 291, 165);
    check("up164_map", 64'(hit_map), 64'(exp_map));
    check("up164_score", 64'(score), 64'd3);

    run_ticks(172, "down_lat");
    check_ball("down173", 635, 509);
    run_tick(lat, bn);
    check("loss2_lat", 64'(lat), 64'd3);
    check("loss2_lives", 64'(lives), 64'd1);
    check_ball("loss2_spawn", 450, 480);
    check("loss2_go", 64'(game_over), 64'd0);

    // Reset mid-SCAN with a stray tick pending.
    @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    repeat (20) @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_ball("mid_rst", 450, 480);
    check("mid_rst_map", 64'(hit_map), 64'd0);
    check("mid_rst_score", 64'(score), 64'd0);
    check("mid_rst_lives", 64'(lives), 64'd3);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_fd", 64'(frame_done), 64'd0);
    check("mid_rst_go", 64'(game_over), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (100) begin
      @(negedge clk);
      if (frame_done) extra++;
    end
    check("post_rst_fd", 64'(extra), 64'd0);
    run_tick(lat, bn);
    check("post_rst_lat", 64'(lat), 64'd64);
    check_ball("post_rst", 452, 478);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
